imem_responder: RTL and testbench

- Instruction-memory responder that serves fetch requests from the processor front end over a valid/ready request and response handshake, with a fixed, parameterised access latency.
- Also has a single-cycle program-load write port used by the bench/loader to fill memory before and between runs.
- Sits between the fetch unit (initiator) and instruction storage; replaces the zero-latency combinational instruction ROM path.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_array.sv | 36 +++
 rtl/imem_responder.sv | 143 ++++++++++++++
 tb/tb_imem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: state encoding,
// instruction width, halt encoding, latency bounds and the address check helper.
package imem_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned PC_W    = 16;
    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;
    localparam int unsigned CNT_W   = 4;

    // Unloaded or rejected fetches return this word, which halts the core.
    localparam logic [INSTR_W-1:0] HALT_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

    // A fetch address is bad if it is misaligned or points beyond the storage.
    function automatic logic addr_bad(input logic [PC_W-1:0] a, input int unsigned aw);
        logic [PC_W-1:0] hi;
        hi = a >> (aw + 1);
        return a[0] | (hi != '0);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: 2**ADDR_W x INSTR_W words, one synchronous write port,
// one combinational read port, every word cleared to HALT_INSTR on reset.
// Ports: clk, rst (async active-low), i_we/i_waddr/i_wdata write,
//        i_raddr/o_rdata read.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]  i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [INSTR_W-1:0] r_mem [DEPTH];

    // Storage with full clear on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[ADDR_W'(i)] <= HALT_INSTR;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time over a valid/ready
// request channel, returns the word LATENCY cycles later over a valid/ready
// response channel, and offers a program-load write port usable only in IDLE.
// Ports: clk, rst (async active-low), err (sticky error),
//        req_valid/req_ready/req_addr (byte PC), resp_valid/resp_ready/resp_instr,
//        load_en/load_addr/load_data (program load).
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               err,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [PC_W-1:0]    req_addr,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [INSTR_W-1:0] resp_instr,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data
);

    imem_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic               r_bad, w_bad_nxt;
    logic [INSTR_W-1:0] r_instr, w_instr_nxt;
    logic               r_err, w_err_nxt;

    logic               w_we;
    logic [ADDR_W-1:0]  w_req_word;
    logic               w_req_bad;
    logic [ADDR_W-1:0]  w_raddr;
    logic [INSTR_W-1:0] w_rdata;

    assign w_req_word = req_addr[ADDR_W:1];
    assign w_req_bad  = addr_bad(req_addr, ADDR_W);

    // In IDLE the only read that matters is the LATENCY==1 capture of the
    // incoming request; afterwards the latched address drives the read.
    assign w_raddr = (r_state == IDLE) ? w_req_word : r_addr;

    imem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_bad   <= 1'b0;
            r_instr <= HALT_INSTR;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_bad   <= w_bad_nxt;
            r_instr <= w_instr_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state, capture, error and handshake logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_bad_nxt   = r_bad;
        w_instr_nxt = r_instr;
        w_err_nxt   = r_err;
        w_we        = 1'b0;
        req_ready   = 1'b0;

        case (r_state)
            IDLE: begin
                // A load owns the cycle; the request waits.
                w_we      = load_en;
                req_ready = rst & ~load_en;
                if (req_valid && !load_en) begin
                    w_addr_nxt = w_req_word;
                    w_bad_nxt  = w_req_bad;
                    if (w_req_bad) begin
                        w_err_nxt = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        w_instr_nxt = w_req_bad ? HALT_INSTR : w_rdata;
                        w_state_nxt = RESP;
                    end else begin
                        w_cnt_nxt   = CNT_W'(LATENCY - 1);
                        w_state_nxt = WAIT;
                    end
                end
            end

            WAIT: begin
                // Loads are refused so the in-flight read stays intact.
                if (load_en) begin
                    w_err_nxt = 1'b1;
                end
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_instr_nxt = r_bad ? HALT_INSTR : w_rdata;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            RESP: begin
                if (load_en) begin
                    w_err_nxt = 1'b1;
                end
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign resp_valid = (r_state == RESP);
    assign resp_instr = r_instr;
    assign err        = r_err;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

    localparam int unsigned AW  = 8;
    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        err;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = 16'h0000;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_instr;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = 8'h00;
    logic [15:0] load_data = 16'h0000;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: plain word array plus sticky error bit.
    logic [15:0] m_mem [256];
    bit          m_err;

    typedef struct {
        bit          is_load;
        logic [15:0] addr;
        logic [15:0] data;
        int          stall;
        logic [15:0] exp_instr;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    imem_responder #(
        .ADDR_W  (AW),
        .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .err        (err),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    function automatic void m_clear();
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
        m_err = 1'b0;
    endfunction

    // Expected word for a fetch; a bad address returns HALT and flags the error.
    function automatic logic [15:0] m_fetch(input logic [15:0] a);
        if (a[0] || (a >> (AW + 1)) != 16'h0) begin
            m_err = 1'b1;
            return 16'h0000;
        end
        return m_mem[a[AW:1]];
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0; load_en = 1'b0; resp_ready = 1'b0;
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_instr", resp_instr, 0);
        check("rst_err", err, 0);
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_ready", req_ready, 1);
        m_clear();
    endtask

    task automatic do_load(input logic [7:0] wa, input logic [15:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = wa; load_data = d;
        req_valid = 1'b1; req_addr = 16'h0000;
        #1;
        check("load_req_ready", req_ready, 0);
        @(negedge clk);
        load_en = 1'b0; req_valid = 1'b0;
        #1;
        check("post_load_ready", req_ready, 1);
        m_mem[wa] = d;
    endtask

    // Called at the negedge right after the acceptance edge.
    task automatic fetch_resp(input int stall, input bit inj, input logic [15:0] exp_i, input bit exp_e);
        int k;
        k = 1;
        if (inj) begin
            load_en = 1'b1; load_addr = 8'h02; load_data = 16'hDEAD;
        end
        #1;
        check("busy_ready", req_ready, 0);
        while (resp_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            load_en = 1'b0;
            k++;
        end
        check("latency", k, LAT);
        check("resp_instr", resp_instr, exp_i);
        check("err", err, exp_e);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            load_en = 1'b0;
            check("hold_valid", resp_valid, 1);
            check("hold_instr", resp_instr, exp_i);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        load_en = 1'b0; resp_ready = 1'b0;
        #1;
        check("post_hs_valid", resp_valid, 0);
        check("post_hs_ready", req_ready, 1);
        check("post_hs_instr", resp_instr, exp_i);
    endtask

    task automatic fetch(input logic [15:0] a, input int stall, input bit inj, input logic [15:0] exp_i, input bit exp_e);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; resp_ready = 1'b0;
        #1;
        check("idle_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_addr = 16'hFFFF;
        fetch_resp(stall, inj, exp_i, exp_e);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] e;
        m_clear();

        vecs.push_back('{0, 16'h0004, 16'h0000, 0, 16'h0000, 0});
        vecs.push_back('{1, 16'h0002, 16'h4125, 0, 16'h0000, 0});
        vecs.push_back('{0, 16'h0004, 16'h0000, 0, 16'h4125, 0});
        vecs.push_back('{0, 16'h0004, 16'h0000, 5, 16'h4125, 0});
        vecs.push_back('{1, 16'h00FF, 16'hBEEF, 0, 16'h0000, 0});
        vecs.push_back('{0, 16'h01FE, 16'h0000, 1, 16'hBEEF, 0});
        vecs.push_back('{0, 16'h0000, 16'h0000, 0, 16'h0000, 0});
        vecs.push_back('{0, 16'h0003, 16'h0000, 0, 16'h0000, 1});
        vecs.push_back('{0, 16'h0004, 16'h0000, 2, 16'h4125, 1});

        do_reset(3);

        foreach (vecs[i]) begin
            if (vecs[i].is_load) begin
                do_load(vecs[i].addr[7:0], vecs[i].data);
            end else begin
                void'(m_fetch(vecs[i].addr));
                fetch(vecs[i].addr, vecs[i].stall, 1'b0, vecs[i].exp_instr, vecs[i].exp_err);
            end
        end

        // Load while a request waits: request held off, then sees the new word.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 16'h0006;
        load_en = 1'b1; load_addr = 8'h03; load_data = 16'h1234;
        #1;
        check("ld_req_ready", req_ready, 0);
        @(negedge clk);
        load_en = 1'b0;
        m_mem[3] = 16'h1234;
        #1;
        check("ld_then_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        fetch_resp(0, 1'b0, 16'h1234, 1'b1);

        // Reset clears memory; out-of-range address flags error.
        do_reset(2);
        fetch(16'h0004, 0, 1'b0, 16'h0000, 1'b0);
        fetch(16'h0400, 0, 1'b0, 16'h0000, 1'b1);

        // Illegal load during WAIT: ignored, error set and sticky.
        do_reset(2);
        do_load(8'h02, 16'h4125);
        fetch(16'h0004, 0, 1'b1, 16'h4125, 1'b1);
        fetch(16'h0004, 1, 1'b0, 16'h4125, 1'b1);

        // Reset mid-fetch drops the request.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 16'h0004;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b1;
        rst = 1'b0;
        #1;
        check("midrst_valid", resp_valid, 0);
        check("midrst_ready", req_ready, 0);
        check("midrst_err", err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_clear();
        #1;
        check("midrst_first_ready", req_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_resp", resp_valid, 0);
        end
        resp_ready = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 3) begin
                do_load(8'($urandom_range(0, 15)), 16'($urandom));
            end else begin
                a = 16'($urandom_range(0, 15)) << 1;
                if (r == 7) a = a | 16'h0001;
                if (r >= 8) a = 16'($urandom) | 16'h0200;
                e = m_fetch(a);
                fetch(a, int'($urandom_range(0, 3)), 1'b0, e, m_err);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
